// File: rtl/jpeg_zz_pkg.sv
// rtl/jpeg_zz_pkg.sv - shared constants and types for the JPEG zigzag-transpose path
// Scan-to-raster table: entry k is the raster index (row*8 + col) of scan position k.
package jpeg_zz_pkg;

   localparam int BLK_WORDS = 8;
   localparam int ZZ_BW     = 8;

   typedef logic [BLK_WORDS-1:0][ZZ_BW-1:0] coef_row_t;

   localparam logic [5:0] SCAN2RASTER [64] = '{
      6'd0,  6'd8,  6'd1,  6'd2,  6'd9,  6'd16, 6'd24, 6'd17,
      6'd10, 6'd3,  6'd4,  6'd11, 6'd18, 6'd25, 6'd32, 6'd40,
      6'd33, 6'd26, 6'd19, 6'd12, 6'd5,  6'd6,  6'd13, 6'd20,
      6'd27, 6'd34, 6'd41, 6'd48, 6'd56, 6'd49, 6'd42, 6'd35,
      6'd28, 6'd21, 6'd14, 6'd7,  6'd15, 6'd22, 6'd29, 6'd36,
      6'd43, 6'd50, 6'd57, 6'd58, 6'd51, 6'd44, 6'd37, 6'd30,
      6'd23, 6'd31, 6'd38, 6'd45, 6'd52, 6'd59, 6'd60, 6'd53,
      6'd46, 6'd39, 6'd47, 6'd54, 6'd61, 6'd62, 6'd55, 6'd63
   };

endpackage

// File: rtl/izz_bank.sv
// rtl/izz_bank.sv - one 64-cell coefficient bank
// Writes scatter a scan-order word into raster cells; reads return one raster row.
module izz_bank
   import jpeg_zz_pkg::*;
#(
   parameter int BW = 8
) (
   input  logic            clk,
   input  logic            wr_en,
   input  logic [2:0]      wr_word,
   input  logic [8*BW-1:0] wr_data,
   input  logic [2:0]      rd_row,
   output logic [8*BW-1:0] rd_data
);

   logic [BW-1:0] mem [64];

   // Slot 0 sits in the MSB lane of the incoming word.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int s = 0; s < BLK_WORDS; s++) begin
            mem[SCAN2RASTER[{wr_word, 3'(s)}]] <= wr_data[(BLK_WORDS-1-s)*BW +: BW];
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int c = 0; c < BLK_WORDS; c++) begin
         rd_data[(BLK_WORDS-1-c)*BW +: BW] = mem[{rd_row, 3'(c)}];
      end
   end

endmodule

// File: rtl/izigzag_tp.sv
// rtl/izigzag_tp.sv - inverse zigzag-transpose ping-pong buffer
// Accepts 8 scan-order words per block and streams 8 raster rows out.
module izigzag_tp
   import jpeg_zz_pkg::*;
#(
   parameter int BW = 8
) (
   input  logic            i_clk,
   input  logic            i_Reset,
   input  logic [8*BW-1:0] i_data,
   input  logic            i_enable,
   output logic            o_ready,
   output logic [8*BW-1:0] o_data,
   output logic            o_valid,
   output logic            o_last,
   input  logic            i_ready
);

   logic [1:0]      full;
   logic [1:0]      full_nxt;
   logic            wr_bank;
   logic            rd_bank;
   logic [2:0]      wr_cnt;
   logic [2:0]      rd_cnt;
   logic            accept;
   logic            load;
   logic            wr_last;
   logic            rd_last;
   logic [8*BW-1:0] bank_rd [2];
   logic [8*BW-1:0] row_sel;

   assign o_ready = ~full[wr_bank];
   assign accept  = i_enable & o_ready;
   assign load    = full[rd_bank] & (~o_valid | i_ready);
   assign wr_last = accept & (wr_cnt == 3'd7);
   assign rd_last = load & (rd_cnt == 3'd7);
   assign row_sel = bank_rd[rd_bank];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      izz_bank #(.BW(BW)) u_bank (
         .clk     (i_clk),
         .wr_en   (accept & (wr_bank == 1'(b))),
         .wr_word (wr_cnt),
         .wr_data (i_data),
         .rd_row  (rd_cnt),
         .rd_data (bank_rd[b])
      );
   end

   // Writer and reader always own different banks, so set and clear never collide.
   always_comb begin
      full_nxt = full;
      if (rd_last) full_nxt[rd_bank] = 1'b0;
      if (wr_last) full_nxt[wr_bank] = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_Reset) begin
      if (i_Reset) begin
         full    <= 2'b00;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_cnt  <= 3'd0;
         rd_cnt  <= 3'd0;
         o_data  <= '0;
         o_valid <= 1'b0;
         o_last  <= 1'b0;
      end else begin
         full <= full_nxt;
         if (accept) begin
            wr_cnt <= wr_cnt + 3'd1;
            if (wr_last) wr_bank <= ~wr_bank;
         end
         // Bank is released when row 7 is loaded, not when it is handed off.
         if (load) begin
            rd_cnt  <= rd_cnt + 3'd1;
            if (rd_last) rd_bank <= ~rd_bank;
            o_data  <= row_sel;
            o_valid <= 1'b1;
            o_last  <= (rd_cnt == 3'd7);
         end else if (o_valid && i_ready) begin
            o_data  <= '0;
            o_valid <= 1'b0;
            o_last  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_izigzag_tp.sv
// tb/tb_izigzag_tp.sv - scoreboard bench for izigzag_tp
// Stimulus pushes expected raster rows; a negedge monitor pops and compares.
module tb_izigzag_tp;

   localparam int BW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [63:0]   i_data = '0;
   logic          i_enable = 1'b0;
   logic          o_ready;
   logic [63:0]   o_data;
   logic          o_valid;
   logic          o_last;
   logic          i_ready = 1'b1;

   typedef struct {
      logic [63:0] data;
      logic        last;
   } exp_t;

   exp_t sb [$];

   int zz [64] = '{
       0,  8,  1,  2,  9, 16, 24, 17, 10,  3,  4, 11, 18, 25, 32, 40,
      33, 26, 19, 12,  5,  6, 13, 20, 27, 34, 41, 48, 56, 49, 42, 35,
      28, 21, 14,  7, 15, 22, 29, 36, 43, 50, 57, 58, 51, 44, 37, 30,
      23, 31, 38, 45, 52, 59, 60, 53, 46, 39, 47, 54, 61, 62, 55, 63
   };

   int   checks = 0;
   int   failures = 0;
   int   rdy_mode = 1;
   int   run_len = 0;
   int   max_run = 0;
   int   ready_drops = 0;
   logic mon_en = 1'b0;
   logic pv = 1'b0;
   logic pr = 1'b0;
   logic pl = 1'b0;
   logic [63:0] pd = '0;

   izigzag_tp #(.BW(BW)) dut (
      .i_clk    (clk),
      .i_Reset  (rst),
      .i_data   (i_data),
      .i_enable (i_enable),
      .o_ready  (o_ready),
      .o_data   (o_data),
      .o_valid  (o_valid),
      .o_last   (o_last),
      .i_ready  (i_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0:       i_ready = 1'b0;
         1:       i_ready = 1'b1;
         default: i_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [63:0] mk_word(input logic [7:0] blk [64], input int w);
      logic [63:0] r;
      r = '0;
      for (int s = 0; s < 8; s++) r[(7-s)*8 +: 8] = blk[zz[8*w+s]];
      return r;
   endfunction

   function automatic logic [63:0] row_of(input logic [7:0] blk [64], input int r);
      logic [63:0] d;
      d = '0;
      for (int c = 0; c < 8; c++) d[(7-c)*8 +: 8] = blk[8*r+c];
      return d;
   endfunction

   task automatic push_rows(input logic [7:0] blk [64]);
      exp_t e;
      for (int r = 0; r < 8; r++) begin
         e.data = row_of(blk, r);
         e.last = (r == 7);
         sb.push_back(e);
      end
   endtask

   // Monitor: row compare on handshake, stall stability, zero-when-idle.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && mon_en) begin
         if (pv && !pr) begin
            check("stall_valid", 64'(o_valid), 64'd1);
            check("stall_data", o_data, pd);
            check("stall_last", 64'(o_last), 64'(pl));
         end
         if (!o_valid) begin
            check("idle_data", o_data, 64'd0);
            check("idle_last", 64'(o_last), 64'd0);
         end
         if (o_valid && i_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_row actual=%h required=none", o_data);
            end else begin
               e = sb.pop_front();
               check("row_data", o_data, e.data);
               check("row_last", 64'(o_last), 64'(e.last));
            end
         end
         if (o_valid) run_len++;
         else run_len = 0;
         if (run_len > max_run) max_run = run_len;
      end
      pv = o_valid;
      pr = i_ready;
      pd = o_data;
      pl = o_last;
   end

   task automatic send_word(input logic [63:0] w, output int stalls);
      logic acc;
      int   bound;
      i_data   = w;
      i_enable = 1'b1;
      stalls   = 0;
      acc      = 1'b0;
      bound    = 0;
      while (!acc) begin
         @(negedge clk);
         acc = o_ready;
         if (!acc) stalls++;
         @(posedge clk);
         #1;
         bound++;
         if (!acc && bound > 300) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=%0d cycles required=accept", bound);
            acc = 1'b1;
         end
      end
   endtask

   task automatic send_block(input logic [7:0] blk [64], input bit gaps);
      int st;
      int g;
      push_rows(blk);
      for (int w = 0; w < 8; w++) begin
         if (gaps) begin
            g = $urandom_range(0, 3);
            if (g > 0) begin
               i_enable = 1'b0;
               repeat (g) @(posedge clk);
               #1;
            end
         end
         send_word(mk_word(blk, w), st);
         ready_drops += st;
      end
      i_enable = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      i_enable = 1'b0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("drain_remaining", 64'(sb.size()), 64'd0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic rand_blk(output logic [7:0] blk [64]);
      for (int i = 0; i < 64; i++) blk[i] = 8'($urandom);
   endtask

   initial begin
      logic [7:0]  blk_a [64];
      logic [7:0]  blk_b [64];
      logic [63:0] words [17];
      int          acc_cnt;
      logic        rdy17;
      int          st;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 64'(o_valid), 64'd0);
      check("rst_data", o_data, 64'd0);
      check("rst_last", 64'(o_last), 64'd0);
      check("rst_ready", 64'(o_ready), 64'd1);
      rst = 1'b0;
      mon_en = 1'b1;
      @(posedge clk);
      #1;

      // Single block: value equals raster index, check first-row latency
      for (int i = 0; i < 64; i++) blk_a[i] = 8'(i);
      send_block(blk_a, 1'b0);
      check("lat_not_yet", 64'(o_valid), 64'd0);
      @(posedge clk);
      #1;
      check("lat_row0_valid", 64'(o_valid), 64'd1);
      check("lat_row0_data", o_data, 64'h0001020304050607);
      drain();

      // Four blocks back-to-back
      max_run = 0;
      ready_drops = 0;
      for (int b = 0; b < 4; b++) begin
         for (int i = 0; i < 64; i++) blk_a[i] = 8'(i * 3 + b * 17);
         send_block(blk_a, 1'b0);
      end
      drain();
      check("b2b_ready_drops", 64'(ready_drops), 64'd0);
      check("b2b_contig_rows", 64'(max_run), 64'd32);

      // Downstream stalled: 16 words absorbed, 17th dropped
      rdy_mode = 0;
      @(posedge clk);
      #2;
      rand_blk(blk_a);
      rand_blk(blk_b);
      push_rows(blk_a);
      push_rows(blk_b);
      for (int w = 0; w < 8; w++) begin
         words[w]     = mk_word(blk_a, w);
         words[w + 8] = mk_word(blk_b, w);
      end
      words[16] = 64'hdeadbeefcafef00d;
      acc_cnt = 0;
      rdy17 = 1'b1;
      for (int k = 0; k < 17; k++) begin
         i_data = words[k];
         i_enable = 1'b1;
         @(negedge clk);
         if (o_ready) acc_cnt++;
         if (k == 16) rdy17 = o_ready;
         @(posedge clk);
         #1;
      end
      i_enable = 1'b0;
      check("stall_accepted", 64'(acc_cnt), 64'd16);
      check("stall_ready17", 64'(rdy17), 64'd0);
      check("stall_hold_valid", 64'(o_valid), 64'd1);
      check("stall_hold_row0", o_data, row_of(blk_a, 0));
      rdy_mode = 1;
      drain();
      check("stall_ready_after", 64'(o_ready), 64'd1);

      // Random enable gaps and random downstream stalls
      rdy_mode = 2;
      for (int b = 0; b < 3; b++) begin
         rand_blk(blk_a);
         send_block(blk_a, 1'b1);
      end
      drain();
      rdy_mode = 1;
      @(posedge clk);
      #1;

      // Reset while block 1 shows row 3 and block 2 has 4 words in
      rand_blk(blk_a);
      rand_blk(blk_b);
      send_block(blk_a, 1'b0);
      for (int w = 0; w < 4; w++) send_word(mk_word(blk_b, w), st);
      #2;
      rst = 1'b1;
      #1;
      check("mid_rst_valid", 64'(o_valid), 64'd0);
      check("mid_rst_data", o_data, 64'd0);
      check("mid_rst_last", 64'(o_last), 64'd0);
      check("mid_rst_ready", 64'(o_ready), 64'd1);
      sb.delete();
      i_enable = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      rand_blk(blk_a);
      send_block(blk_a, 1'b0);
      drain();

      // Round trip: forward scan of random raster blocks must come back unchanged
      for (int b = 0; b < 2; b++) begin
         rand_blk(blk_a);
         send_block(blk_a, 1'b0);
      end
      drain();

      check("sb_empty", 64'(sb.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #400000;
      failures++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/izigzag_tp.md
# izigzag_tp

Inverse zigzag-transpose buffer for the JPEG decode path. It accepts a coefficient block as 8 words of 8 coefficients each, in transposed-zigzag scan order, which is the order the forward zigzag-transpose stage emits. It scatters them into raster position and streams the block back out as 8 raster rows, row 0 first. Two ping-pong banks let the next block be written while the current one is read, so throughput is sustained at one word per cycle.

## Interface
- `BW`, 8, coefficient width in bits; a word is 8*BW bits.
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_Reset`  in  1  asynchronous, active-high reset.
- `i_data`  in  8*BW  8 scan-order coefficients; slot 0 in bits [8*BW-1:7*BW], slot 7 in [BW-1:0].
- `i_enable`  in  1  upstream word valid.
- `o_ready`  out  1  block can accept a word this cycle.
- `o_data`  out  8*BW  raster row; column 0 in the MSB slot, column 7 in the LSB slot.
- `o_valid`  out  1  `o_data` holds a valid row.
- `o_last`  out  1  the current row is row 7 of its block; qualified by `o_valid`.
- `i_ready`  in  1  downstream accepts `o_data` this cycle.

## Operation
- Scan position k = 8*word + slot, for k = 0..63.
- The raster index (row*8 + col) of position k is entry k of: 0,8,1,2,9,16,24,17,10,3,4,11,18,25,32,40,33,26,19,12,5,6,13,20,27,34,41,48,56,49,42,35,28,21,14,7,15,22,29,36,43,50,57,58,51,44,37,30,23,31,38,45,52,59,60,53,46,39,47,54,61,62,55,63.
- Write side:
  - A word is accepted only when `i_enable` and `o_ready` are both high.
  - The 3-bit word counter `wr_cnt` selects the 8 target cells in bank `wr_bank`.
  - `i_enable` while `o_ready` is low is ignored: nothing is written and no counter advances.
  - Gaps in `i_enable` are legal. A partial block is held indefinitely.
  - On acceptance with `wr_cnt`=7: set `full[wr_bank]`, toggle `wr_bank`, wrap `wr_cnt` to 0.
- Write/read bookkeeping:
  - `o_ready = ~full[wr_bank]`.
  - Set and clear of `full` for different banks in the same cycle both take effect.
- Read side:
  - The output register loads when `full[rd_bank]` is set and (`o_valid`==0 or `i_ready`==1).
  - A load places row `rd_cnt` of bank `rd_bank` into `o_data`, sets `o_valid`, and sets `o_last` = (`rd_cnt`==7).
  - Loading row 7 clears `full[rd_bank]`, toggles `rd_bank`, and wraps `rd_cnt`. The bank is released at load time, not at handshake.
  - If `o_valid` and `i_ready` are both high and no load occurs, `o_valid` drops and `o_data` and `o_last` go to 0.
  - `o_data` is 0 whenever `o_valid` is 0.
- Reset values: `o_data`=0, `o_valid`=0, `o_last`=0, `o_ready`=1. `wr_cnt`, `rd_cnt`, `wr_bank` and `rd_bank` are 0; `full`=2'b00. Bank storage is not cleared.
- Reset asserted mid-operation: all partial and full blocks are discarded and the block returns to the reset state immediately (asynchronously).

## Timing
- If the 8th word of a block is accepted at edge E, row 0 is visible with `o_valid`=1 after edge E+1.
- With `i_ready` high, rows 1..7 follow on edges E+2..E+8.
- Bank release happens at edge E+8, which keeps `o_ready` high for continuous back-to-back blocks at one word per cycle in and one row per cycle out.
- `o_ready` is a combinational decode of registered state and has no path from `i_enable`.
- With `i_ready` held low, at most 16 words are absorbed, then `o_ready` falls.
- Stalled outputs are held stable: `o_data`, `o_valid` and `o_last` do not change while `o_valid`=1 and `i_ready`=0.

## Structure
- Shared package `jpeg_zz_pkg` holds:
  - the 64-entry scan-to-raster constant array above;
  - `BLK_WORDS`=8;
  - a `coef_row_t` typedef, 8 x BW bits.
- Sub-module `izz_bank`, instantiated twice:
  - one 64 x BW storage bank;
  - write port takes an 8-cell scatter from the constant table;
  - read port returns one full row.
- The top level holds the counters, `full` flags, bank pointers and the output register.

## Test plan
- Single block, `i_ready`=1:
  - Stimulus: scan position k carries the value of its raster index.
  - Response: rows are 0..7, 8..15, …, 56..63. Row 0 appears one cycle after the 8th word; `o_last` is high only on row 7.
- Four blocks back-to-back, `i_enable`=1, `i_ready`=1:
  - Response: `o_ready` never drops; 32 contiguous valid rows, raster-correct per block.
- `i_ready` held at 0, `i_enable` continuous:
  - Response: 16 words are accepted, `o_ready`=0 from the 17th cycle on, and the 17th word is dropped. After `i_ready` rises, both blocks drain intact.
- Random `i_enable` gaps and random `i_ready` stalls:
  - Response: output matches a raster-reorder reference model, and `o_data` is held stable during every stall.
- Reset at word 5 of block 2 while block 1 is outputting row 3:
  - Response: `o_valid`=0 and `o_data`=0 at once, `o_ready`=1. A fresh block afterwards decodes correctly.
- Round trip through the forward zigzag-transpose stage using random BW=8 data:
  - Response: the output rows equal the original input rows.
